// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Shared SDRAM definitions for the command engines under the arbiter.
//   - Command encodings on {CS_n, RAS_n, CAS_n, WE_n}
//   - State type of the auto-refresh FSM
//   - Counter width helper (bits needed to hold a given maximum value)
// -----------------------------------------------------------------------------
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PREC = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREC,
      ST_TRP_W,
      ST_AREF,
      ST_TRFC_W,
      ST_DONE
   } aref_state_t;

   // Bits needed to represent max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// -----------------------------------------------------------------------------
// sdram_aref_timer
//   Free-running refresh interval timer. Counts 0..TREFI_CYC-1 and wraps; tick
//   is high for the single cycle in which the count equals TREFI_CYC-1. Only a
//   reset restarts it, so refresh ticks stay on a fixed grid regardless of
//   when refreshes are actually granted.
// Ports
//   sclk    in   clock
//   srst_n  in   synchronous active-low reset
//   tick    out  one cycle per TREFI_CYC cycles (combinational from count)
// -----------------------------------------------------------------------------
module sdram_aref_timer
   import sdram_pkg::*;
#(
   parameter int TREFI_CYC = 749
) (
   input  logic sclk,
   input  logic srst_n,
   output logic tick
);

   localparam int               CNT_W    = cnt_width(TREFI_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TREFI_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sdram_aref_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_aref_ctrl
//   Parametrised SDRAM auto-refresh engine. A free-running tREFI timer accrues
//   refresh debt (saturating at MAX_PEND, sticky overflow beyond it). The debt
//   drives aref_req/aref_urgent toward the command arbiter. Once granted, the
//   engine issues PREC-all, waits tRP, then issues up to AREF_BURST AREF
//   commands spaced by tRFC, and pulses flag_aref_end. A started sequence
//   always runs to completion.
// Ports
//   sclk           in   clock
//   srst_n         in   synchronous active-low reset
//   aref_en        in   arbiter grant, held until flag_aref_end
//   aref_req       out  debt > 0
//   aref_urgent    out  debt >= URGENT_TH
//   pend_cnt       out  current refresh debt
//   aref_ovf       out  sticky: tick arrived with debt already at MAX_PEND
//   sdram_cmd      out  {CS_n,RAS_n,CAS_n,WE_n}, registered
//   sdram_addr     out  constant, only A10 (all banks) set
//   flag_aref_end  out  one-cycle registered pulse at end of sequence
// -----------------------------------------------------------------------------
module sdram_aref_ctrl
   import sdram_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int TREFI_CYC  = 749,
   parameter int TRP_CYC    = 2,
   parameter int TRFC_CYC   = 4,
   parameter int AREF_BURST = 2,
   parameter int MAX_PEND   = 8,
   parameter int URGENT_TH  = 6
) (
   input  logic                          sclk,
   input  logic                          srst_n,
   input  logic                          aref_en,
   output logic                          aref_req,
   output logic                          aref_urgent,
   output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
   output logic                          aref_ovf,
   output logic [3:0]                    sdram_cmd,
   output logic [ADDR_W-1:0]             sdram_addr,
   output logic                          flag_aref_end
);

   localparam int                PEND_W    = $clog2(MAX_PEND + 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
   localparam logic [PEND_W-1:0] URG_LVL   = PEND_W'(URGENT_TH);

   localparam int                 BURST_W   = cnt_width(AREF_BURST);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(AREF_BURST);

   // One wait counter serves both tRP and tRFC; it is loaded with the number
   // of wait-state cycles minus one and the wait state exits when it hits zero.
   localparam int                WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
   localparam int                WAIT_W   = cnt_width(WAIT_MAX);
   localparam logic [WAIT_W-1:0] TRP_LD   = WAIT_W'((TRP_CYC  > 1) ? TRP_CYC  - 2 : 0);
   localparam logic [WAIT_W-1:0] TRFC_LD  = WAIT_W'((TRFC_CYC > 1) ? TRFC_CYC - 2 : 0);

   logic               tick;
   logic               aref_issue;
   aref_state_t        state;
   logic [BURST_W-1:0] burst;
   logic [BURST_W-1:0] burst_post;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               more;

   sdram_aref_timer #(
      .TREFI_CYC (TREFI_CYC)
   ) u_timer (
      .sclk   (sclk),
      .srst_n (srst_n),
      .tick   (tick)
   );

   assign aref_req    = (pend_cnt != '0);
   assign aref_urgent = (pend_cnt >= URG_LVL);
   assign sdram_addr  = ADDR_W'(1) << 10;

   // An AREF is on the bus for the whole ST_AREF cycle; its debt is retired
   // at the edge that leaves that cycle.
   assign aref_issue = (state == ST_AREF);

   // -------------------------------------------------------------------------
   // Refresh debt and overflow flag
   // -------------------------------------------------------------------------
   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         pend_cnt <= '0;
         aref_ovf <= 1'b0;
      end else begin
         if (tick && (pend_cnt == PEND_MAX)) begin
            aref_ovf <= 1'b1;
         end
         if (tick && !aref_issue) begin
            if (pend_cnt != PEND_MAX) begin
               pend_cnt <= pend_cnt + 1'b1;
            end
         end else if (!tick && aref_issue) begin
            pend_cnt <= pend_cnt - 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-AREF decision, evaluated on the post-AREF view of debt and burst.
   // From ST_AREF (only reached directly when TRFC_CYC == 1) the decrement and
   // burst increment of the current AREF have not landed yet, so they are
   // folded in here.
   // -------------------------------------------------------------------------
   always_comb begin
      burst_post = burst;
      more       = 1'b0;
      if (state == ST_AREF) begin
         burst_post = burst + 1'b1;
         more       = (burst_post < BURST_MAX) && (pend_cnt > PEND_W'(1));
      end else begin
         more       = (burst < BURST_MAX) && (pend_cnt != '0);
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer; sdram_cmd and flag_aref_end are registered alongside the state
   // so the command on the bus always matches the state being occupied.
   // -------------------------------------------------------------------------
   always_ff @(posedge sclk) begin
      if (!srst_n) begin
         state         <= ST_IDLE;
         sdram_cmd     <= CMD_NOP;
         flag_aref_end <= 1'b0;
         burst         <= '0;
         wait_cnt      <= '0;
      end else begin
         sdram_cmd     <= CMD_NOP;
         flag_aref_end <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (aref_en && aref_req) begin
                  state     <= ST_PREC;
                  sdram_cmd <= CMD_PREC;
               end
            end
            ST_PREC: begin
               if (TRP_CYC > 1) begin
                  state    <= ST_TRP_W;
                  wait_cnt <= TRP_LD;
               end else begin
                  state     <= ST_AREF;
                  sdram_cmd <= CMD_AREF;
               end
            end
            ST_TRP_W: begin
               if (wait_cnt == '0) begin
                  state     <= ST_AREF;
                  sdram_cmd <= CMD_AREF;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_AREF: begin
               burst <= burst_post;
               if (TRFC_CYC > 1) begin
                  state    <= ST_TRFC_W;
                  wait_cnt <= TRFC_LD;
               end else if (more) begin
                  sdram_cmd <= CMD_AREF;
               end else begin
                  state         <= ST_DONE;
                  flag_aref_end <= 1'b1;
               end
            end
            ST_TRFC_W: begin
               if (wait_cnt == '0) begin
                  if (more) begin
                     state     <= ST_AREF;
                     sdram_cmd <= CMD_AREF;
                  end else begin
                     state         <= ST_DONE;
                     flag_aref_end <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               // aref_en is deliberately not sampled here.
               burst <= '0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               burst <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_aref_ctrl
//   Scoreboard bench for sdram_aref_ctrl. A cycle-level reference model keeps
//   the refresh debt as plain arithmetic over elapsed cycles and, on each
//   grant, schedules the expected bus events (PREC, AREFs, end pulse) with
//   absolute cycle stamps into a queue. A separate monitor pops an event
//   whenever the DUT drives a non-NOP command or the end pulse and compares
//   cycle and content; it also compares debt-derived outputs every cycle.
// -----------------------------------------------------------------------------
module tb_sdram_aref_ctrl;
   import sdram_pkg::*;

   localparam int ADDR_W = 12;
   localparam int TREFI  = 749;
   localparam int TRP    = 2;
   localparam int TRFC   = 4;
   localparam int BURST  = 2;
   localparam int MAXP   = 8;
   localparam int URG    = 6;
   localparam int PW     = $clog2(MAXP + 1);

   logic              sclk = 1'b0;
   logic              srst_n;
   logic              aref_en;
   logic              aref_req;
   logic              aref_urgent;
   logic [PW-1:0]     pend_cnt;
   logic              aref_ovf;
   logic [3:0]        sdram_cmd;
   logic [ADDR_W-1:0] sdram_addr;
   logic              flag_aref_end;

   sdram_aref_ctrl #(
      .ADDR_W     (ADDR_W),
      .TREFI_CYC  (TREFI),
      .TRP_CYC    (TRP),
      .TRFC_CYC   (TRFC),
      .AREF_BURST (BURST),
      .MAX_PEND   (MAXP),
      .URGENT_TH  (URG)
   ) dut (
      .sclk          (sclk),
      .srst_n        (srst_n),
      .aref_en       (aref_en),
      .aref_req      (aref_req),
      .aref_urgent   (aref_urgent),
      .pend_cnt      (pend_cnt),
      .aref_ovf      (aref_ovf),
      .sdram_cmd     (sdram_cmd),
      .sdram_addr    (sdram_addr),
      .flag_aref_end (flag_aref_end)
   );

   initial forever #5 sclk = ~sclk;

   typedef struct {
      longint     at;
      logic [3:0] cmd;
      logic       flag;
   } ev_t;

   ev_t    exp_q[$];
   ev_t    cur_ev;
   int     pass_cnt  = 0;
   int     total_cnt = 0;

   // Reference model state
   longint n_cyc     = 0;     // rising edges seen
   longint since_rst = 0;     // rising edges since the last reset edge
   longint last_aref = -100;  // edge after which the latest AREF is on the bus
   longint idle_from = 0;     // first edge at which a grant may be sampled
   int     m_debt    = 0;
   bit     m_ovf     = 1'b0;
   bit     m_busy    = 1'b0;
   int     m_burst   = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      total_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, n_cyc);
   endtask

   task automatic push_ev(input longint at, input logic [3:0] cmd, input logic flag);
      ev_t e;
      e.at   = at;
      e.cmd  = cmd;
      e.flag = flag;
      exp_q.push_back(e);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: updated at each rising edge from the inputs sampled there.
   // ---------------------------------------------------------------------------
   initial forever begin
      @(posedge sclk);
      n_cyc++;
      if (!srst_n) begin
         since_rst = 0;
         m_debt    = 0;
         m_ovf     = 1'b0;
         m_busy    = 1'b0;
         m_burst   = 0;
         last_aref = -100;
         idle_from = 0;
         exp_q.delete();
      end else begin
         bit tick;
         bit dec;
         int live;
         since_rst++;
         tick = ((since_rst % TREFI) == 0);
         dec  = (n_cyc == last_aref + 1);
         if (m_busy) begin
            if (n_cyc == last_aref + TRFC) begin
               live = m_debt - (dec ? 1 : 0);
               if (m_burst < BURST && live > 0) begin
                  last_aref = n_cyc;
                  m_burst++;
                  push_ev(n_cyc, CMD_AREF, 1'b0);
               end else begin
                  push_ev(n_cyc, CMD_NOP, 1'b1);
                  m_busy    = 1'b0;
                  idle_from = n_cyc + 2;
               end
            end
         end else if (aref_en && m_debt > 0 && n_cyc >= idle_from) begin
            m_busy    = 1'b1;
            m_burst   = 1;
            last_aref = n_cyc + TRP;
            push_ev(n_cyc, CMD_PREC, 1'b0);
            push_ev(n_cyc + TRP, CMD_AREF, 1'b0);
         end
         if (tick && m_debt == MAXP) m_ovf = 1'b1;
         m_debt = m_debt + int'(tick) - int'(dec);
         if (m_debt > MAXP) m_debt = MAXP;
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: 1 time unit after each rising edge.
   // ---------------------------------------------------------------------------
   initial forever begin
      @(posedge sclk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].at < n_cyc) begin
         total_cnt++;
         $display("FAIL missing_event: cmd %b flag %b due at cycle %0d not seen (now %0d)",
                  exp_q[0].cmd, exp_q[0].flag, exp_q[0].at, n_cyc);
         void'(exp_q.pop_front());
      end
      if (sdram_cmd != CMD_NOP || flag_aref_end) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: cmd %b flag %b at cycle %0d, expected NOP and no flag",
                     sdram_cmd, flag_aref_end, n_cyc);
         end else begin
            cur_ev = exp_q.pop_front();
            chk("event_cycle", n_cyc, cur_ev.at);
            chk("event_cmd", sdram_cmd, cur_ev.cmd);
            chk("event_flag", flag_aref_end, cur_ev.flag);
         end
      end
      chk("pend_cnt", pend_cnt, m_debt);
      chk("aref_req", aref_req, m_debt > 0);
      chk("aref_urgent", aref_urgent, m_debt >= URG);
      chk("aref_ovf", aref_ovf, m_ovf);
      chk("sdram_addr", sdram_addr, 1 << 10);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ---------------------------------------------------------------------------
   task automatic run(input int k);
      repeat (k) @(negedge sclk);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((m_busy || n_cyc + 1 < idle_from) && k < 500) begin
         @(negedge sclk);
         k++;
      end
      if (k >= 500) begin
         total_cnt++;
         $display("FAIL idle_timeout: engine still busy after %0d cycles, expected idle", k);
      end
   endtask

   task automatic pulse_reset();
      srst_n = 1'b0;
      @(negedge sclk);
      srst_n = 1'b1;
   endtask

   // Grant like the arbiter: raise aref_en and hold it until flag_aref_end,
   // optionally dropping it early after 'hold' cycles and keeping it for
   // 'extra' cycles past the end pulse.
   task automatic grant(input int hold, input int extra);
      int k   = 0;
      bit got = 1'b0;
      wait_idle();
      aref_en = 1'b1;
      if (m_debt == 0) begin
         run((hold < 4) ? hold : 4);
         aref_en = 1'b0;
         return;
      end
      while (!got && k < 200) begin
         @(negedge sclk);
         k++;
         if (k == hold) aref_en = 1'b0;
         if (flag_aref_end) got = 1'b1;
      end
      if (!got) begin
         total_cnt++;
         $display("FAIL grant_timeout: no flag_aref_end within %0d cycles, expected one", k);
      end
      run(extra);
      aref_en = 1'b0;
   endtask

   task automatic wait_debt(input int lvl);
      int k = 0;
      while (m_debt < lvl && k < 3000) begin
         @(negedge sclk);
         k++;
      end
      if (k >= 3000) begin
         total_cnt++;
         $display("FAIL debt_timeout: debt %0d, expected to reach %0d", m_debt, lvl);
      end
   endtask

   initial begin
      int k;
      srst_n  = 1'b0;
      aref_en = 1'b0;
      run(3);
      srst_n = 1'b1;

      // First tick after 749 cycles, no commands without a grant.
      run(TREFI + 5);

      // Single-debt grant: PREC, one AREF, end pulse.
      grant(1000, 0);

      // Grant with no debt: nothing happens.
      grant(3, 0);

      // Debt of three: two AREFs, then a second grant for the remainder.
      wait_debt(3);
      grant(1000, 0);
      grant(1000, 0);

      // Long starvation: saturation, urgent and overflow.
      run(9 * TREFI + 10);

      // Align a grant so the first AREF retires on a tick edge; drop the grant
      // early to show the burst runs to completion.
      wait_idle();
      k = 0;
      while (((since_rst + 4) % TREFI) != 0 && k < 2 * TREFI) begin
         @(negedge sclk);
         k++;
      end
      grant(2, 0);

      // Reset in the middle of tRFC wait, then watch the timer restart.
      wait_idle();
      aref_en = 1'b1;
      k = 0;
      while (sdram_cmd != CMD_AREF && k < 20) begin
         @(negedge sclk);
         k++;
      end
      if (k >= 20) begin
         total_cnt++;
         $display("FAIL aref_timeout: no AREF seen within %0d cycles, expected one", k);
      end
      @(negedge sclk);
      aref_en = 1'b0;
      pulse_reset();
      run(TREFI + 5);

      // Randomised traffic, including early drops, back-to-back grants and resets.
      for (int i = 0; i < 14; i++) begin
         run($urandom_range(1500, 0));
         if ($urandom_range(7, 0) == 0) pulse_reset();
         grant(($urandom_range(1, 0) == 1) ? int'($urandom_range(12, 1)) : 1000,
               int'($urandom_range(3, 0)));
      end

      wait_idle();
      run(5);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
